// File: rtl/cordic_atan2_mag.sv
// cordic_atan2_mag: iterative vectoring-mode CORDIC.
// Converts a Q2.14 Cartesian vector (x_in, y_in) into
//   angle_radian = atan2(y, x), Q3.14 radians (16384 = 1 rad, range +/-pi)
//   magnitude    = sqrt(x^2 + y^2), unsigned Q2.14
// One micro-rotation per clock. A start/done handshake mirrors cordic_sin_cos.
// Optional feature: define CORDIC_START_ERR_EN to add a start_err output.
// start_err pulses for one cycle whenever start arrives while busy.
module cordic_atan2_mag #(
    parameter int ITER = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    output logic        busy,
    output logic        done,
    output logic [16:0] angle_radian,
    output logic [15:0] magnitude
`ifdef CORDIC_START_ERR_EN
    ,
    output logic        start_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROTATE,
        ST_SCALE,
        ST_DONE
    } state_t;

    localparam logic signed [17:0] HALF_PI = 18'sd25736;
    localparam logic signed [17:0] K_Q15   = 18'sd19898;  // 0.60725 in Q1.15

    state_t state, state_next;

    logic signed [17:0] x_r, y_r, z_r;
    logic        [3:0]  iter;
    logic               zero_r;

    logic signed [17:0] xs, ys;
    logic signed [17:0] pre_x, pre_y, pre_z;
    logic signed [17:0] atan_val;
    logic signed [17:0] x_shift, y_shift;
    logic signed [35:0] prod;
    logic signed [35:0] scaled;
    logic        [15:0] mag_sat;
    logic               accept;

    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign busy   = (state == ST_ROTATE) || (state == ST_SCALE);
    assign done   = (state == ST_DONE);

    // State register; reset is synchronous and aborts any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic for the IDLE -> ROTATE -> SCALE -> DONE sequence.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (accept) state_next = ST_ROTATE;
            ST_ROTATE:        if (iter == 4'(ITER - 1)) state_next = ST_SCALE;
            ST_SCALE:         state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Quadrant pre-rotation brings the vector into the right half-plane.
    always_comb begin
        xs    = {{2{x_in[15]}}, x_in};
        ys    = {{2{y_in[15]}}, y_in};
        pre_x = xs;
        pre_y = ys;
        pre_z = '0;
        if (xs < 0) begin
            if (ys >= 0) begin
                pre_x = ys;
                pre_y = -xs;
                pre_z = HALF_PI;
            end else begin
                pre_x = -ys;
                pre_y = xs;
                pre_z = -HALF_PI;
            end
        end
    end

    // Arctangent table atan(2^-i) in Q3.14.
    always_comb begin
        atan_val = '0;
        case (iter)
            4'd0:  atan_val = 18'sd12868;
            4'd1:  atan_val = 18'sd7596;
            4'd2:  atan_val = 18'sd4014;
            4'd3:  atan_val = 18'sd2037;
            4'd4:  atan_val = 18'sd1023;
            4'd5:  atan_val = 18'sd512;
            4'd6:  atan_val = 18'sd256;
            4'd7:  atan_val = 18'sd128;
            4'd8:  atan_val = 18'sd64;
            4'd9:  atan_val = 18'sd32;
            4'd10: atan_val = 18'sd16;
            4'd11: atan_val = 18'sd8;
            4'd12: atan_val = 18'sd4;
            4'd13: atan_val = 18'sd2;
            default: atan_val = '0;
        endcase
    end

    // Micro-rotation shifts and the gain-compensated, rounded, saturated magnitude.
    always_comb begin
        x_shift = y_r >>> iter;
        y_shift = x_r >>> iter;
        prod    = x_r * K_Q15;
        scaled  = (prod + 36'sd16384) >>> 15;
        if (scaled < 0)               mag_sat = '0;
        else if (scaled > 36'sd65535) mag_sat = 16'hFFFF;
        else                          mag_sat = scaled[15:0];
    end

    // Datapath: capture at start, rotate once per clock, scale into the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r          <= '0;
            y_r          <= '0;
            z_r          <= '0;
            iter         <= '0;
            zero_r       <= 1'b0;
            angle_radian <= '0;
            magnitude    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        x_r    <= pre_x;
                        y_r    <= pre_y;
                        z_r    <= pre_z;
                        iter   <= '0;
                        zero_r <= (x_in == 16'd0) && (y_in == 16'd0);
                    end
                end
                ST_ROTATE: begin
                    // A zero vector stays at (0,0,0) so the outputs come out as zero.
                    if (!zero_r) begin
                        if (y_r >= 0) begin
                            x_r <= x_r + x_shift;
                            y_r <= y_r - y_shift;
                            z_r <= z_r + atan_val;
                        end else begin
                            x_r <= x_r - x_shift;
                            y_r <= y_r + y_shift;
                            z_r <= z_r - atan_val;
                        end
                    end
                    iter <= iter + 4'd1;
                end
                ST_SCALE: begin
                    magnitude    <= mag_sat;
                    angle_radian <= z_r[16:0];
                end
                default: ;
            endcase
        end
    end

`ifdef CORDIC_START_ERR_EN
    // One-cycle flag for a start request that arrives while an operation is running.
    always_ff @(posedge clk) begin
        if (reset) start_err <= 1'b0;
        else       start_err <= start && busy;
    end
`endif

endmodule

// File: tb/tb_cordic_atan2_mag.sv
// tb_cordic_atan2_mag: directed-vector bench with a scoreboard queue.
// Stimulus pushes expected angle/magnitude/done-cycle; a monitor pops on each
// rising done and compares within the stated tolerances.
module tb_cordic_atan2_mag;

    localparam int ITER = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] x_in, y_in;
    logic        busy, done;
    logic [16:0] angle_radian;
    logic [15:0] magnitude;
`ifdef CORDIC_START_ERR_EN
    logic        start_err;
`endif

    cordic_atan2_mag #(.ITER(ITER)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .x_in         (x_in),
        .y_in         (y_in),
        .busy         (busy),
        .done         (done),
        .angle_radian (angle_radian),
        .magnitude    (magnitude)
`ifdef CORDIC_START_ERR_EN
        ,
        .start_err    (start_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    ea;
        int    em;
        int    ta;
        int    tm;
        int    due;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input int act, input int exp, input int tol);
        int diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        tests_run++;
        if (diff > tol) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Monitor: on each rising done, pop the oldest expectation and compare.
    exp_t e;
    logic done_q = 1'b0;
    int   err_pulses = 0;
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_latency"}, cyc, e.due, 0);
                check({e.name, "_angle"}, int'($signed(angle_radian)), e.ea, e.ta);
                check({e.name, "_mag"}, int'(magnitude), e.em, e.tm);
            end
        end
        done_q = done;
`ifdef CORDIC_START_ERR_EN
        if (start_err) err_pulses++;
`endif
    end

    // Called on a falling edge; start is sampled on the next rising edge.
    task automatic issue(input logic [15:0] x, input logic [15:0] y,
                         input int ea, input int em, input int ta, input int tm,
                         input string name);
        exp_t n;
        x_in  = x;
        y_in  = y;
        start = 1'b1;
        n.name = name;
        n.ea   = ea;
        n.em   = em;
        n.ta   = ta;
        n.tm   = tm;
        n.due  = cyc + 1 + ITER + 1;
        sb.push_back(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) return;
        end
        tests_run++;
        tests_failed++;
        $display("FAIL %s_timeout: done not seen within 40 cycles, expected done", name);
    endtask

    task automatic run(input logic [15:0] x, input logic [15:0] y,
                       input int ea, input int em, input int ta, input int tm,
                       input string name);
        issue(x, y, ea, em, ta, tm, name);
        wait_done(name);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",  int'(busy), 0, 0);
        check("reset_done",  int'(done), 0, 0);
        check("reset_angle", int'($signed(angle_radian)), 0, 0);
        check("reset_mag",   int'(magnitude), 0, 0);
        reset = 1'b0;
        @(negedge clk);

        // Main function and quadrant coverage.
        run(16'sd16384,  16'sd0,       0,      16384, 4, 3, "x_axis");
        run(16'sd14189,  16'sd8192,    8579,   16384, 4, 3, "deg30");
        run(16'sd11585,  16'sd11585,   12868,  16384, 4, 3, "deg45");
        run(16'sd0,      16'sd16384,   25736,  16384, 4, 3, "pos_y");
        run(16'sd0,     -16'sd16384,  -25736,  16384, 4, 3, "neg_y");
        run(-16'sd16384, 16'sd0,       51472,  16384, 4, 3, "neg_x");
        run(-16'sd11585,-16'sd11585,  -38604,  16384, 4, 3, "q3");
        run(16'sd0,      16'sd0,       0,      0,     0, 0, "zero");
        run(16'h8000,    16'h8000,    -38604,  46341, 4, 3, "max_neg");

        // start re-asserted mid-ROTATE with different inputs must be ignored.
        issue(16'sd14189, 16'sd8192, 8579, 16384, 4, 3, "ignored_start");
        repeat (3) @(negedge clk);
        x_in  = 16'sd0;
        y_in  = 16'sd16384;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start");
`ifdef CORDIC_START_ERR_EN
        check("start_err_pulses", err_pulses, 1, 0);
`endif

        // Back-to-back starts accepted directly from DONE.
        issue(16'sd0, -16'sd16384, -25736, 16384, 4, 3, "b2b_1");
        wait_done("b2b_1");
        issue(-16'sd16384, 16'sd0, 51472, 16384, 4, 3, "b2b_2");
        wait_done("b2b_2");
        @(negedge clk);

        // Reset mid-ROTATE discards the operation and clears the outputs.
        issue(16'sd11585, 16'sd11585, 12868, 16384, 4, 3, "aborted");
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy",  int'(busy), 0, 0);
        check("abort_done",  int'(done), 0, 0);
        check("abort_angle", int'($signed(angle_radian)), 0, 0);
        check("abort_mag",   int'(magnitude), 0, 0);
        sb.delete();
        reset = 1'b0;
        @(negedge clk);
        run(16'sd14189, 16'sd8192, 8579, 16384, 4, 3, "after_abort");

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
